// File: rtl/branch_seq_if.sv
// branch_seq_if: request/response bundle between decode, branch_seq and PC-select.
//   master: requester side (drives request fields and resp_ready)
//   slave : branch_seq side (drives req_ready and result fields)
interface branch_seq_if #(parameter int XLEN = 32);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] dataA;
    logic [XLEN-1:0] dataB;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            resp_valid;
    logic            resp_ready;
    logic            BrEq;
    logic            BrLT;
    logic            taken;
    logic [XLEN-1:0] next_pc;
    logic            illegal;
    logic            busy;
    modport master (
        output req_valid, funct3, dataA, dataB, pc, imm, resp_ready,
        input  req_ready, resp_valid, BrEq, BrLT, taken, next_pc, illegal, busy
    );
    modport slave (
        input  req_valid, funct3, dataA, dataB, pc, imm, resp_ready,
        output req_ready, resp_valid, BrEq, BrLT, taken, next_pc, illegal, busy
    );
endinterface

// File: rtl/branch_seq.sv
// branch_seq: multi-cycle RV32I branch resolver, slice-serial MSB-first magnitude compare.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : branch_seq_if.slave (request funct3/dataA/dataB/pc/imm, response
//              BrEq/BrLT/taken/next_pc/illegal, busy)
//   BRSEQ_EARLY_EXIT_EN : when defined, CMP stops at the first differing slice;
//                         otherwise it always scans all NSLICE slices.
module branch_seq #(
    parameter int XLEN    = 32,
    parameter int SLICE_W = 4
) (
    input logic         clk,
    input logic         rst,
    branch_seq_if.slave bus
);
    localparam int NSLICE = XLEN / SLICE_W;
    localparam int IW     = NSLICE > 1 ? $clog2(NSLICE) : 1;
    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
    state_t state, state_n;
    logic [XLEN-1:0]    a_q, b_q, pc_q, imm_q;
    logic [IW-1:0]      idx;
    logic               op_lt, op_neg;
    logic [SLICE_W-1:0] sa, sb;
    logic               fin, lt_n, eq_n, tk_n, bad_op;
`ifndef BRSEQ_EARLY_EXIT_EN
    // dec: a differing slice was already seen; dlt: its verdict
    logic               dec, dlt;
`endif
    assign sa            = a_q[int'(idx)*SLICE_W +: SLICE_W];
    assign sb            = b_q[int'(idx)*SLICE_W +: SLICE_W];
    assign bad_op        = bus.funct3[2:1] == 2'b01;
    // funct3[2] picks lt vs eq, funct3[0] negates it
    assign tk_n          = (op_lt ? lt_n : eq_n) ^ op_neg;
    assign bus.req_ready = state == IDLE;
    assign bus.resp_valid = state == DONE;
    assign bus.busy      = state != IDLE;
    always_comb begin
`ifdef BRSEQ_EARLY_EXIT_EN
        fin  = (sa != sb) || (idx == '0);
        lt_n = sa < sb;
        eq_n = sa == sb;
`else
        fin  = idx == '0;
        lt_n = dec ? dlt : sa < sb;
        eq_n = !dec && sa == sb;
`endif
        state_n = state;
        if (state == IDLE && bus.req_valid) state_n = bad_op ? DONE : CMP;
        if (state == CMP && fin) state_n = DONE;
        if (state == DONE && bus.resp_ready) state_n = IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
            op_lt       <= 1'b0;
            op_neg      <= 1'b0;
            idx         <= IW'(NSLICE - 1);
            bus.BrEq    <= 1'b0;
            bus.BrLT    <= 1'b0;
            bus.taken   <= 1'b0;
            bus.next_pc <= '0;
            bus.illegal <= 1'b0;
`ifndef BRSEQ_EARLY_EXIT_EN
            dec         <= 1'b0;
            dlt         <= 1'b0;
`endif
        end else if (state == IDLE && bus.req_valid) begin
            // signed ops flip the sign bits so the slice compare stays unsigned
            a_q    <= bus.dataA ^ {!bus.funct3[1], {(XLEN-1){1'b0}}};
            b_q    <= bus.dataB ^ {!bus.funct3[1], {(XLEN-1){1'b0}}};
            pc_q   <= bus.pc;
            imm_q  <= bus.imm;
            op_lt  <= bus.funct3[2];
            op_neg <= bus.funct3[0];
            idx    <= IW'(NSLICE - 1);
`ifndef BRSEQ_EARLY_EXIT_EN
            dec    <= 1'b0;
`endif
            if (bad_op) begin
                bus.illegal <= 1'b1;
                bus.BrEq    <= 1'b0;
                bus.BrLT    <= 1'b0;
                bus.taken   <= 1'b0;
                bus.next_pc <= bus.pc + XLEN'(4);
            end
        end else if (state == CMP) begin
            if (fin) begin
                bus.BrEq    <= eq_n;
                bus.BrLT    <= lt_n;
                bus.taken   <= tk_n;
                bus.next_pc <= tk_n ? pc_q + imm_q : pc_q + XLEN'(4);
                bus.illegal <= 1'b0;
            end else begin
                idx <= idx - 1'b1;
`ifndef BRSEQ_EARLY_EXIT_EN
                dec <= dec || (sa != sb);
                dlt <= lt_n;
`endif
            end
        end
    end
endmodule

// File: tb/tb_branch_seq.sv
// tb_branch_seq: directed + random check of branch_seq against an arithmetic reference model.
module tb_branch_seq;
    localparam int XLEN = 32;
    localparam int SW   = 4;
    localparam int NS   = XLEN / SW;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad   = 0;
    always #5 clk = ~clk;
    branch_seq_if #(.XLEN(XLEN)) bus ();
    branch_seq #(.XLEN(XLEN), .SLICE_W(SW)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic scramble();
        bus.funct3 = 3'($urandom);
        bus.dataA  = $urandom;
        bus.dataB  = $urandom;
        bus.pc     = $urandom;
        bus.imm    = $urandom;
    endtask

    task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] im, input int stall);
        logic ill, eq, lt, tk;
        logic [31:0] npc;
        int k, lead, cyc;
        ill = (f3 == 3'b010) || (f3 == 3'b011);
        eq  = a == b;
        lt  = f3[1] ? (a < b) : ($signed(a) < $signed(b));
        case (f3)
            3'b000:         tk = eq;
            3'b001:         tk = !eq;
            3'b100, 3'b110: tk = lt;
            3'b101, 3'b111: tk = !lt;
            default:        tk = 1'b0;
        endcase
        npc = tk ? p + im : p + 32'd4;
        if (ill) begin
            eq = 1'b0;
            lt = 1'b0;
        end
        lead = 0;
        for (int i = NS - 1; i >= 0; i--) begin
            if ((((a ^ b) >> (i * SW)) & 32'((1 << SW) - 1)) != 0) break;
            lead++;
        end
`ifdef BRSEQ_EARLY_EXIT_EN
        k = (lead == NS) ? NS : lead + 1;
`else
        k = NS;
`endif
        if (ill) k = 0;
        @(negedge clk);
        check("req_ready_idle", 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.funct3 = f3;
        bus.dataA = a;
        bus.dataB = b;
        bus.pc = p;
        bus.imm = im;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        scramble();
        cyc = 0;
        @(negedge clk);
        while (!bus.resp_valid && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        check("latency", 32'(cyc), 32'(k));
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) @(negedge clk);
            check("resp_valid", 32'(bus.resp_valid), 1);
            check("req_ready_busy", 32'(bus.req_ready), 0);
            check("busy", 32'(bus.busy), 1);
            check("BrEq", 32'(bus.BrEq), 32'(eq));
            check("BrLT", 32'(bus.BrLT), 32'(lt));
            check("taken", 32'(bus.taken), 32'(tk));
            check("next_pc", bus.next_pc, npc);
            check("illegal", 32'(bus.illegal), 32'(ill));
        end
        // handshake cycle, with a competing request that must be ignored
        bus.resp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.funct3 = 3'b000;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("resp_drop", 32'(bus.resp_valid), 0);
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_ready", 32'(bus.req_ready), 1);
        check("idle_hold_taken", 32'(bus.taken), 32'(tk));
        check("idle_hold_pc", bus.next_pc, npc);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [2:0] f3;
        int cyc;
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 1);
        check("rst_resp_valid", 32'(bus.resp_valid), 0);
        check("rst_BrEq", 32'(bus.BrEq), 0);
        check("rst_BrLT", 32'(bus.BrLT), 0);
        check("rst_taken", 32'(bus.taken), 0);
        check("rst_next_pc", bus.next_pc, 0);
        check("rst_illegal", 32'(bus.illegal), 0);
        check("rst_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        run(3'b000, 32'hDEADBEEF, 32'hDEADBEEF, 32'h100, 32'h20, 0);
        run(3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h200, 32'hFFFFFFF0, 0);
        run(3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h200, 32'hFFFFFFF0, 0);
        run(3'b101, 32'h12345678, 32'h12345670, 32'h300, 32'h8, 0);
        run(3'b111, 32'h80000000, 32'h00000000, 32'h400, 32'h40, 0);
        run(3'b001, 32'h5, 32'h5, 32'h500, 32'h10, 5);
        run(3'b010, 32'h1, 32'h2, 32'h600, 32'h30, 1);
        run(3'b011, 32'h7, 32'h7, 32'hFFFFFFFC, 32'h30, 0);
        run(3'b000, 32'h1, 32'h2, 32'hFFFFFFF0, 32'h20, 0);
        // reset during the third CMP cycle of an all-equal compare
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.funct3 = 3'b000;
        bus.dataA = 32'h0F0F0F0F;
        bus.dataB = 32'h0F0F0F0F;
        bus.pc = 32'h700;
        bus.imm = 32'h8;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_resp_valid", 32'(bus.resp_valid), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_req_ready", 32'(bus.req_ready), 1);
        check("abort_next_pc", bus.next_pc, 0);
        check("abort_illegal", 32'(bus.illegal), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.resp_valid) cyc++;
        end
        check("abort_no_resp", 32'(cyc), 0);
        run(3'b001, 32'h1, 32'h2, 32'h800, 32'h40, 0);
        repeat (200) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ (32'($urandom_range(1, 15)) << (4 * $urandom_range(0, NS - 1)));
                2:       b = a ^ 32'h80000000;
                default: b = $urandom;
            endcase
            f3 = 3'($urandom);
            run(f3, a, b, $urandom, $urandom, $urandom_range(0, 2));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_seq.md
Name: branch_seq

Overview:
- Multi-cycle branch resolution controller for the RV32I core.
- Accepts one branch request (funct3, two register operands, pc, imm) over a valid/ready handshake.
- Sequences a slice-wide magnitude compare MSB-slice-first, then derives BrEq/BrLT, the taken decision and the next PC.
- Sits between decode and PC-select logic; returns results on a valid/ready response port.

Parameters:
- XLEN, 32, operand, pc and imm width.
- SLICE_W, 4, bits compared per CMP cycle; must divide XLEN; NSLICE = XLEN/SLICE_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- funct3  in  3  branch funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU).
- dataA  in  XLEN  rs1 value.
- dataB  in  XLEN  rs2 value.
- pc  in  XLEN  branch instruction address.
- imm  in  XLEN  sign-extended B-immediate.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- BrEq  out  1  A == B.
- BrLT  out  1  A < B, signed or unsigned per funct3.
- taken  out  1  branch taken.
- next_pc  out  XLEN  pc+imm if taken, else pc+4.
- illegal  out  1  funct3 is 010 or 011.
- busy  out  1  state != IDLE.

Behaviour:
- States are IDLE, CMP and DONE. Reset state is IDLE.
- Reset values: req_ready=1, resp_valid=0, BrEq=0, BrLT=0, taken=0, next_pc=0, illegal=0, busy=0, slice index=NSLICE-1.
- Accept: req_valid&&req_ready at an edge latches every input.
  - For signed ops (funct3[1]=0), the MSB of both latched operands is inverted, so every compare is unsigned internally.
  - Legal funct3 goes to CMP with idx=NSLICE-1.
  - Illegal funct3 goes straight to DONE with illegal=1, taken=0, BrEq=0, BrLT=0, next_pc=pc+4.
- CMP, one slice per cycle at idx:
  - Slice A < slice B: lt=1, eq=0, go to DONE.
  - Slice A > slice B: lt=0, eq=0, go to DONE.
  - Slices equal and idx==0: eq=1, lt=0, go to DONE.
  - Slices equal and idx>0: idx decrements, stay in CMP.
- Taken decision:
  - BEQ: eq.
  - BNE: !eq.
  - BLT/BLTU: lt.
  - BGE/BGEU: !lt.
- next_pc:
  - Computed with modulo-2^XLEN wrap; no alignment check.
  - Registered on the CMP→DONE transition.
- DONE:
  - resp_valid=1; all result outputs are held stable until resp_valid&&resp_ready.
  - On that handshake, go to IDLE; resp_valid drops the next cycle.
  - No new request is accepted in the handshake cycle.
- Latency:
  - Accept edge → k CMP cycles → resp_valid high. k = 1 + number of leading equal slices (1..NSLICE). Illegal funct3: k = 0.
- Result outputs keep their last values in IDLE.
- Input changes after acceptance have no effect.
- rst asserted in any state immediately returns all outputs to their reset values. Any in-flight request is discarded with no response.

Optional Feature:
- Macro BRSEQ_EARLY_EXIT_EN.
- Defined: CMP terminates at the first differing slice (variable latency as above).
- Undefined:
  - CMP always runs all NSLICE cycles (fixed latency NSLICE).
  - The first differing slice from MSB still determines lt/eq; later slices are scanned but ignored.
  - Results are identical in both builds.

Test Plan:
- BEQ, A=B=0xDEADBEEF, pc=0x100, imm=0x20, resp_ready=1 → after 8 CMP cycles: BrEq=1, BrLT=0, taken=1, next_pc=0x120.
- BLT, A=0xFFFFFFFF (-1), B=0x00000001, pc=0x200, imm=0xFFFFFFF0 → k=1 (early exit): BrLT=1, taken=1, next_pc=0x1F0. BLTU on the same operands → BrLT=0, taken=0, next_pc=0x204.
- BGE, A=0x12345678, B=0x12345670 → k=8 in both builds: BrLT=0, BrEq=0, taken=1. Repeat with macro undefined and A=0x80000000, B=0 (BGEU) → k=8, taken=1.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid → outputs stable and req_ready=0 throughout; resp_ready=1 → IDLE next cycle; a new request is accepted the following cycle.
- funct3=010 → resp_valid the cycle after accept, illegal=1, taken=0, next_pc=pc+4.
- rst pulsed during the 3rd CMP cycle → resp_valid=0 and busy=0 immediately; no response for the aborted request; a subsequent BNE A=1, B=2 resolves with taken=1.
